// File: rtl/segment_click_control.sv
// Two-button click counter for a single seven-segment digit.
// Buttons are synchronized, debounced and edge-detected into clicks.
module segment_click_control #(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int MAX_COUNT       = 9,
    parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] MAXC = 4'(MAX_COUNT);
    localparam logic [6:0] SEG_ZERO = 7'b1111110;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'ha:    s = 7'b1110111;
            4'hb:    s = 7'b0011111;
            4'hc:    s = 7'b1001110;
            4'hd:    s = 7'b0111101;
            4'he:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // bit 0 = up, bit 1 = down
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_prev;
    logic [1:0]    armed;
    logic [1:0]    click;
    logic [CW-1:0] db_cnt  [2];
    logic [CW-1:0] arm_cnt [2];
    logic [3:0]    count;
    logic [3:0]    count_next;
    logic [6:0]    seg;
    logic [6:0]    seg_next;

    assign raw = {down, up};

    // A button only becomes armed after a full debounce period of
    // confirmed release, so a press held through reset never clicks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            armed   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i]  <= '0;
                arm_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
                if (armed[i] || sync2[i] || db[i]) begin
                    arm_cnt[i] <= '0;
                end else if (arm_cnt[i] == DB_LAST) begin
                    armed[i] <= 1'b1;
                end else begin
                    arm_cnt[i] <= arm_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign click = db & ~db_prev & armed;

    always_comb begin
        count_next = count;
        if (click[0] && !click[1]) begin
            count_next = (count >= MAXC) ? 4'd0 : count + 4'd1;
        end else if (click[1] && !click[0]) begin
            count_next = (count == 4'd0) ? MAXC : count - 4'd1;
        end
    end

    always_comb begin
        seg_next = decode(count);
        if (SEG_ACTIVE_LOW) begin
            seg_next = ~seg_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            seg   <= SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
        end else begin
            count <= count_next;
            seg   <= seg_next;
        end
    end

    assign {out1, out2, out3, out4, out5, out6, out7} = seg;

endmodule

// File: tb/tb_segment_click_control.sv
// Scoreboard bench for segment_click_control with a short debounce.
// Stimulus queues expected display changes; a monitor pops and checks them.
module tb_segment_click_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up = 1'b0;
    logic down = 1'b0;
    logic out1, out2, out3, out4, out5, out6, out7;
    logic [6:0] seg;

    int passed = 0;
    int total = 0;
    bit mon_on = 1'b0;

    logic [6:0] exp_q[$];
    logic [6:0] probe_q[$];

    logic [6:0] dig [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    segment_click_control #(
        .DEBOUNCE_CYCLES(4),
        .MAX_COUNT(9),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up(up),
        .down(down),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .out4(out4),
        .out5(out5),
        .out6(out6),
        .out7(out7)
    );

    assign seg = {out1, out2, out3, out4, out5, out6, out7};

    always #4 clk = ~clk;

    initial begin
        logic [6:0] prev;
        logic [6:0] e;
        wait (mon_on);
        prev = seg;
        forever begin
            @(posedge clk);
            #1;
            if (probe_q.size() > 0) begin
                e = probe_q.pop_front();
                total++;
                if (seg == e) passed++;
                else $display("FAIL probe: got %b want %b", seg, e);
            end
            if (seg != prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: got %b want %b", seg, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (seg == e) passed++;
                    else $display("FAIL change: got %b want %b", seg, e);
                end
                prev = seg;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_seg(input logic [6:0] v);
        exp_q.push_back(v);
    endtask

    task automatic probe(input logic [6:0] v);
        probe_q.push_back(v);
        cyc(2);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL %s: got %0d pending changes want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic click_up(input int hold, input int rel);
        up = 1'b1;
        cyc(hold);
        up = 1'b0;
        cyc(rel);
    endtask

    task automatic click_down(input int hold, input int rel);
        down = 1'b1;
        cyc(hold);
        down = 1'b0;
        cyc(rel);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        mon_on = 1'b1;
        probe(dig[0]);
        cyc(20);
        probe(dig[0]);
        rst = 1'b1;
        cyc(10);
        probe(dig[0]);

        expect_seg(dig[1]);
        click_up(20, 20);
        drain("up1");
        probe(dig[1]);
        expect_seg(dig[2]);
        click_up(20, 20);
        drain("up2");

        expect_seg(dig[3]);
        expect_seg(dig[2]);
        up = 1'b1;
        cyc(20);
        up = 1'b0;
        down = 1'b1;
        cyc(20);
        down = 1'b0;
        cyc(20);
        drain("up3_down");
        probe(dig[2]);

        expect_seg(dig[0]);
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(10);
        drain("reset0");
        for (int i = 1; i <= 10; i++) begin
            expect_seg(dig[i % 10]);
            click_up(10, 10);
        end
        drain("wrap_up");
        expect_seg(dig[9]);
        click_down(10, 10);
        drain("wrap_down");

        expect_seg(dig[0]);
        for (int i = 0; i < 20; i++) begin
            up = ~up;
            cyc(2);
        end
        up = 1'b1;
        cyc(20);
        up = 1'b0;
        cyc(20);
        drain("bounce");
        probe(dig[0]);

        up = 1'b1;
        down = 1'b1;
        cyc(20);
        probe(dig[0]);
        up = 1'b0;
        down = 1'b0;
        cyc(20);
        probe(dig[0]);

        expect_seg(dig[1]);
        up = 1'b1;
        cyc(20);
        drain("pre_rst");
        expect_seg(dig[0]);
        rst = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(30);
        drain("rst_held");
        probe(dig[0]);
        up = 1'b0;
        cyc(20);
        probe(dig[0]);
        expect_seg(dig[1]);
        click_up(20, 20);
        drain("after_rst");
        probe(dig[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
